// File: rtl/op_feeder_pkg.sv
// Shared definitions for the op_feeder host-side core driver.
package op_feeder_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        RUN       = 2'd2,
        CAPTURE   = 2'd3
    } state_e;

    // Ceiling log2 usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < value) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/op_feeder_fifo.sv
// Operand-pair FIFO: DEPTH entries, show-ahead read, wrap-bit pointers.
module op_fifo
    import op_feeder_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * DATA_W_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means every slot is occupied.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Next storage and pointer values; pushes and pops are guarded here.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Storage and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/op_feeder.sv
// Host-side driver for the start/busy/InA/InB/Out processor core interface.
// Queues operand pairs, issues one computation at a time, captures results.
module op_feeder
    import op_feeder_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              core_start,
    output logic [DATA_W-1:0] core_InA,
    output logic [DATA_W-1:0] core_InB,
    input  logic              core_busy,
    input  logic [DATA_W-1:0] core_Out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              timeout_err
);

    localparam int unsigned      TMR_W   = clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                start_q, start_d;
    logic [DATA_W-1:0]   ina_q, ina_d;
    logic [DATA_W-1:0]   inb_q, inb_d;
    logic                res_valid_q, res_valid_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                err_q, err_d;

    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2*DATA_W-1:0] fifo_rdata;
    logic                slot_free;

    op_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .wdata ({in_a, in_b}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The result slot may be refilled in the same cycle it is drained.
    assign slot_free = !res_valid_q || res_ready;

    // Next-state, timer, operand and result logic.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        start_d     = 1'b0;
        ina_d       = ina_q;
        inb_d       = inb_q;
        res_valid_d = res_valid_q && !res_ready;
        res_data_d  = res_data_q;
        err_d       = err_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && slot_free) begin
                    fifo_pop       = 1'b1;
                    {ina_d, inb_d} = fifo_rdata;
                    start_d        = 1'b1;
                    timer_d        = '0;
                    state_d        = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (timer_q == TMR_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (core_busy) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (timer_q == TMR_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (!core_busy) begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                // core_Out is taken one cycle after busy falls.
                res_data_d  = core_Out;
                res_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            start_q     <= 1'b0;
            ina_q       <= '0;
            inb_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            start_q     <= start_d;
            ina_q       <= ina_d;
            inb_q       <= inb_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign core_start  = start_q;
    assign core_InA    = ina_q;
    assign core_InB    = inb_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_op_feeder.sv
// Self-checking bench for op_feeder: emulated core, queue-based reference model.
module tb_op_feeder;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       core_start;
    logic [7:0] core_InA;
    logic [7:0] core_InB;
    logic       core_busy = 1'b0;
    logic [7:0] core_Out = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       timeout_err;

    op_feeder #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .core_start  (core_start),
        .core_InA    (core_InA),
        .core_InB    (core_InB),
        .core_busy   (core_busy),
        .core_Out    (core_Out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int starts = 0;
    int last_start_cyc = 0;
    int err_rise_cyc = 0;
    logic err_prev = 1'b0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Reference model: pending pairs, one op in flight, one result slot.
    logic [15:0] mq[$];
    logic [7:0]  delivered[$];
    bit          m_start, m_rv, m_err, m_inflight, m_cap, m_seen;
    logic [7:0]  m_a = '0, m_b = '0, m_rd = '0;
    int          m_age;

    always @(posedge clk) begin : model
        bit acc;
        bit rv_pre;
        logic [15:0] e;
        if (!reset) begin
            mq.delete();
            m_start = 0; m_rv = 0; m_err = 0; m_inflight = 0; m_cap = 0; m_seen = 0;
            m_a = '0; m_b = '0; m_rd = '0; m_age = 0;
        end else begin
            acc     = in_valid && (mq.size() < DEPTH);
            rv_pre  = m_rv;
            m_start = 0;
            if (m_rv && res_ready) begin
                delivered.push_back(m_rd);
                m_rv = 0;
            end
            if (m_cap) begin
                m_rd  = core_Out;
                m_rv  = 1;
                m_cap = 0;
            end else if (m_inflight) begin
                if (m_age == TIMEOUT) begin
                    m_err      = 1;
                    m_inflight = 0;
                end else begin
                    m_age++;
                    if (!m_seen) begin
                        if (core_busy) m_seen = 1;
                    end else if (!core_busy) begin
                        m_inflight = 0;
                        m_cap      = 1;
                    end
                end
            end else if (mq.size() > 0 && (!rv_pre || res_ready)) begin
                e          = mq.pop_front();
                m_a        = e[15:8];
                m_b        = e[7:0];
                m_start    = 1;
                m_inflight = 1;
                m_age      = 0;
                m_seen     = 0;
            end
            if (acc) mq.push_back({in_a, in_b});
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        cyc++;
        if (core_start === 1'b1) begin
            starts++;
            last_start_cyc = cyc;
        end
        if (timeout_err === 1'b1 && !err_prev) err_rise_cyc = cyc;
        err_prev = timeout_err;
        chk("in_ready",    32'(in_ready),    32'(mq.size() < DEPTH));
        chk("core_start",  32'(core_start),  32'(m_start));
        chk("core_InA",    32'(core_InA),    32'(m_a));
        chk("core_InB",    32'(core_InB),    32'(m_b));
        chk("res_valid",   32'(res_valid),   32'(m_rv));
        chk("res_data",    32'(res_data),    32'(m_rd));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
    end

    // Core emulator: busy after a delay, result valid once busy drops.
    bit         rand_core = 0;
    int         hang_mode = 0;
    int         fix_dly = 0;
    int         fix_len = 4;
    int         emu_wait = -1;
    int         emu_run = 0;
    logic [7:0] emu_sum = '0;

    always @(negedge clk) begin : core_emu
        int mode;
        if (!reset) begin
            core_busy = 0;
            emu_wait  = -1;
            emu_run   = 0;
        end else begin
            if (core_start === 1'b1) begin
                emu_sum = core_InA + core_InB;
                if (rand_core) begin
                    mode     = ($urandom_range(0, 39) == 0) ? 1 : (($urandom_range(0, 39) == 0) ? 2 : 0);
                    emu_wait = int'($urandom_range(0, 3));
                    emu_run  = int'($urandom_range(1, 6));
                end else begin
                    mode     = hang_mode;
                    emu_wait = fix_dly;
                    emu_run  = fix_len;
                end
                if (mode == 1) emu_wait = -1;
                if (mode == 2) emu_run = 1 << 30;
                core_busy = 0;
            end
            if (emu_wait == 0) begin
                core_busy = 1;
                emu_wait  = -1;
                core_Out  = 8'($urandom);
            end else if (emu_wait > 0) begin
                emu_wait--;
            end else if (core_busy) begin
                if (emu_run <= 1) begin
                    core_busy = 0;
                    core_Out  = emu_sum;
                end else begin
                    emu_run--;
                    core_Out = 8'($urandom);
                end
            end
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1; in_a = a; in_b = b;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", 32'(in_ready), 32'(1));
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_results(input int target, input string name);
        int n;
        n = 0;
        while (delivered.size() < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(delivered.size()), 32'(target));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int s0;
        int d0;
        int n;
        int seen_rv;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),    32'(1));
        chk("rst_res_valid", 32'(res_valid),   32'(0));
        chk("rst_start",     32'(core_start),  32'(0));
        chk("rst_err",       32'(timeout_err), 32'(0));
        reset = 1;

        // 1: single op, busy four cycles, result held under backpressure.
        fix_dly = 0; fix_len = 4; res_ready = 0;
        s0 = starts; d0 = delivered.size();
        push(8'h05, 8'h03);
        idle_in();
        n = 0;
        while (!res_valid && n < 100) begin @(negedge clk); n++; end
        chk("t1_res_valid", 32'(res_valid), 32'(1));
        chk("t1_res_data",  32'(res_data),  32'h08);
        chk("t1_starts",    32'(starts - s0), 32'(1));
        repeat (3) @(negedge clk);
        chk("t1_hold_valid", 32'(res_valid), 32'(1));
        chk("t1_hold_data",  32'(res_data),  32'h08);
        res_ready = 1;
        @(negedge clk);
        chk("t1_drained", 32'(res_valid), 32'(0));
        chk("t1_deliver", 32'(delivered[d0]), 32'h08);

        // 2: fill the FIFO behind a long-running op.
        fix_len = 20;
        d0 = delivered.size();
        push(8'h10, 8'h01);
        idle_in();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) push(8'(8'h20 + i), 8'(i));
        @(negedge clk);
        in_valid = 0;
        chk("t2_full", 32'(in_ready), 32'(0));
        push(8'h24, 8'h04);
        idle_in();
        wait_results(d0 + 6, "t2_count");
        chk("t2_r0", 32'(delivered[d0]), 32'h11);
        for (int k = 0; k < 5; k++) chk("t2_order", 32'(delivered[d0 + 1 + k]), 32'(8'(8'h20 + 2 * k)));

        // 3: result backpressure blocks the next issue.
        fix_len = 3; res_ready = 0;
        s0 = starts; d0 = delivered.size();
        push(8'h40, 8'h02);
        push(8'h50, 8'h03);
        idle_in();
        n = 0;
        while (!res_valid && n < 100) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        chk("t3_blocked", 32'(starts - s0), 32'(1));
        res_ready = 1;
        wait_results(d0 + 2, "t3_count");
        chk("t3_starts", 32'(starts - s0), 32'(2));
        chk("t3_r0", 32'(delivered[d0]),     32'h42);
        chk("t3_r1", 32'(delivered[d0 + 1]), 32'h53);

        // 6: ten sequential ops wrap the pointers twice.
        fix_len = 2;
        d0 = delivered.size();
        for (int i = 0; i < 10; i++) push(8'(i), 8'(i + 1));
        idle_in();
        wait_results(d0 + 10, "t6_count");
        for (int i = 0; i < 10; i++) chk("t6_order", 32'(delivered[d0 + i]), 32'(2 * i + 1));

        // 4: core never raises busy; abort after TIMEOUT+1 cycles.
        hang_mode = 1;
        d0 = delivered.size();
        push(8'h22, 8'h11);
        idle_in();
        n = 0;
        while (!timeout_err && n < 400) begin @(negedge clk); n++; end
        #1;
        chk("t4_err",     32'(timeout_err), 32'(1));
        chk("t4_latency", 32'(err_rise_cyc - last_start_cyc), 32'(TIMEOUT + 1));
        chk("t4_no_res",  32'(res_valid), 32'(0));
        hang_mode = 0;
        push(8'h30, 8'h04);
        idle_in();
        wait_results(d0 + 1, "t4_count");
        chk("t4_next",   32'(delivered[d0]), 32'h34);
        chk("t4_sticky", 32'(timeout_err), 32'(1));

        // 5: reset while the core is running.
        fix_len = 50;
        push(8'h01, 8'h01);
        push(8'h02, 8'h02);
        push(8'h03, 8'h03);
        idle_in();
        repeat (5) @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1;
        chk("t5_start", 32'(core_start),  32'(0));
        chk("t5_valid", 32'(res_valid),   32'(0));
        chk("t5_err",   32'(timeout_err), 32'(0));
        chk("t5_ina",   32'(core_InA),    32'(0));
        chk("t5_inb",   32'(core_InB),    32'(0));
        chk("t5_data",  32'(res_data),    32'(0));
        chk("t5_ready", 32'(in_ready),    32'(1));
        s0 = starts; seen_rv = 0;
        repeat (60) begin
            @(negedge clk);
            if (res_valid === 1'b1) seen_rv++;
        end
        chk("t5_no_res",    32'(seen_rv), 32'(0));
        chk("t5_no_starts", 32'(starts - s0), 32'(0));

        // Randomized traffic against the model.
        rand_core = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid = 0; res_ready = 1;
        repeat (700) @(negedge clk);
        rand_core = 0;
        chk("end_valid", 32'(res_valid), 32'(0));
        chk("end_ready", 32'(in_ready),  32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
